bin2bcd_seq: RTL
================

# bin2bcd_seq

Sequential double-dabble binary-to-BCD converter sitting directly downstream of the FIFO's `dout` on the display path. It replaces the combinational `%`/`/` digit split with a WL-cycle shift-and-add-3 engine and feeds packed decimal digits to the BCD_7 seven-segment driver. A single-pulse `start`/`done` handshake lets the top level request a conversion whenever the FIFO output changes.

## Interface
- `WL`, 8, width of the binary input.
- `ND`, 3, number of BCD digits produced; digit 0 is ones.

- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `start`  in  1  conversion request; sampled only while `busy`=0.
- `bin`  in  WL  unsigned binary value; captured on the accepted `start` edge.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse: `bcd`/`ovf` have just been updated.
- `bcd`  out  4*ND  result digits; bits [3:0] ones, [7:4] tens, [11:8] hundreds, and so on.
- `ovf`  out  1  result exceeded 10^ND−1; valid with `done`, held until the next `done`.

## Operation
- Reset (`RST`=0, any time, including mid-conversion): state IDLE, `busy`=0, `done`=0, `ovf`=0, `bcd`=encoding of value 0 (see Configuration). The counter and scratch registers are cleared. An in-flight conversion is discarded.
- States:
  - IDLE: `start`=1 loads `bin` into the shift register, clears the BCD scratch register and the sticky overflow bit, sets the counter to 0, and moves to SHIFT.
  - SHIFT: each cycle, every scratch digit ≥5 gets +3 (digits adjusted in parallel). The combined {scratch, shift} register then shifts left 1; the `bin` MSB enters the ones-digit LSB. The counter increments. When counter = WL−1, this is the last shift: `bcd` is written, `ovf` is written, `done` goes to 1, and the state returns to IDLE.
- Overflow: any 1 shifted out of the top digit's MSB sets the sticky overflow bit. `bcd` then holds the low ND decimal digits (truncated, not saturated).
- `start` while `busy`=1 is ignored and not queued. `bin` changes during SHIFT have no effect.
- `bcd` holds the last result between conversions. It is not cleared on `start`.
- Arithmetic: digit adjust is 4-bit add with no carry-out, because the digit is ≤9 before adjust. The counter width is $clog2(WL), minimum 1.

## Timing
- `start` accepted at edge k → `busy`=1 after edge k. Shifts occur at edges k+1 … k+WL.
- At edge k+WL: `bcd`/`ovf` are updated, `done`=1 and `busy`=0 for exactly one cycle.
- The earliest next `start` is accepted at edge k+WL+1, so the conversion period is WL+1 cycles.
- `busy`, `done`, `bcd` and `ovf` are all registered outputs; there are no combinational input→output paths.

## Configuration
- `BIN2BCD_BLANK_EN`: leading-zero blanking.
  - Defined: at the `done` update, every zero digit above the most significant nonzero digit is replaced by 4'hF, the blank code, which the downstream decoder treats as segments off. The ones digit is never blanked. Reset value of `bcd` is {F…F,0}.
  - Undefined: digits pass through unmodified, and the reset value of `bcd` is all zeros.

## Structure
- Package `bin2bcd_pkg`:
  - state enum (IDLE, SHIFT)
  - `BCD_BLANK` = 4'hF
  - `ADJ_THRESH` = 5
  - `ADJ_ADD` = 3
- Sub-module `bcd_digit_adj`: combinational 4-bit "if ≥5 add 3" cell, instantiated ND times via generate.

## Test plan
- Reset, then `bin`=255, pulse `start` → `busy` for 8 cycles; `done` at edge k+8 with `bcd`=12'h255, `ovf`=0.
- `bin`=0 → `bcd`=12'h000, or 12'hFF0 with `BIN2BCD_BLANK_EN`; `bin`=7 with blanking → 12'hFF7.
- Back-to-back: 99 then 100, with the second `start` at edge k+9 → `done` pulses 9 cycles apart, yielding 12'h099 then 12'h100. A second `start` at k+3 is ignored.
- `bin` changed from 42 to 200 mid-SHIFT → result 12'h042.
- `RST` low at the 4th SHIFT cycle → all outputs return to reset values immediately, no `done`. The next conversion of 128 → 12'h128.
- ND=2, `bin`=200 → `ovf`=1, `bcd`=8'h00; `bin`=99 → `ovf`=0, `bcd`=8'h99.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Input is never above 9, so the 4-bit sum cannot wrap.
    assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// WL-cycle shift-and-add-3 binary-to-BCD converter with a start/done handshake.
// Optional leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WL = 8,
    parameter int ND = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [WL-1:0]   bin,
    output logic            busy,
    output logic            done,
    output logic [4*ND-1:0] bcd,
    output logic            ovf
);

    localparam int CW = (WL > 1) ? $clog2(WL) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WL - 1);

    function automatic logic [4*ND-1:0] reset_code();
        logic [4*ND-1:0] r;
        r = '0;
`ifdef BIN2BCD_BLANK_EN
        for (int i = 1; i < ND; i++) r[4*i +: 4] = BCD_BLANK;
`endif
        return r;
    endfunction

    localparam logic [4*ND-1:0] BCD_RESET = reset_code();

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WL-1:0]   shift_reg;
    logic [4*ND-1:0] scratch;
    logic            ovf_sticky;

    logic [4*ND-1:0] adj;
    logic [4*ND-1:0] next_scratch;
    logic            next_ovf;
    logic [4*ND-1:0] result;

    for (genvar i = 0; i < ND; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[4*i +: 4]),
            .dout (adj[4*i +: 4])
        );
    end

    // The bit leaving the top digit is the overflow indication.
    assign next_scratch = {adj[4*ND-2:0], shift_reg[WL-1]};
    assign next_ovf     = ovf_sticky | adj[4*ND-1];

`ifdef BIN2BCD_BLANK_EN
    logic leading;

    always_comb begin
        result  = next_scratch;
        leading = 1'b1;
        for (int i = ND - 1; i > 0; i--) begin
            if (leading && (next_scratch[4*i +: 4] == 4'd0)) begin
                result[4*i +: 4] = BCD_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign result = next_scratch;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            cnt        <= '0;
            shift_reg  <= '0;
            scratch    <= '0;
            ovf_sticky <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
            bcd        <= BCD_RESET;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg  <= bin;
                        scratch    <= '0;
                        ovf_sticky <= 1'b0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch    <= next_scratch;
                    shift_reg  <= {shift_reg[WL-2:0], 1'b0};
                    ovf_sticky <= next_ovf;
                    cnt        <= cnt + CW'(1);
                    if (cnt == LAST_CNT) begin
                        bcd   <= result;
                        ovf   <= next_ovf;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
